if_id_buffer: RTL
=================

# if_id_buffer

Parametrised fetch/decode boundary buffer: a DEPTH-entry in-order queue between instruction fetch and decode. It replaces the single-entry IF/ID register and adds:
- valid/ready handshakes on both sides;
- a carried branch-prediction bit;
- configurable PC width and queue depth.

Mispredict flush from EX and jump squash from ID keep their bubble semantics: an empty queue presents `NOP_INST` with PC 0 to decode.

## Interface
Parameters:
- `XLEN`, 32, PC/address width in bits.
- `DEPTH`, 2, number of queue entries; power of two, ≥1.
- `NOP_INST`, 32'h0000_0000, instruction word presented to decode when no valid entry.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `if_valid`  in  1  fetch presents an instruction this cycle.
- `if_ready`  out  1  buffer accepts a fetch this cycle.
- `if_inst`  in  32  fetched instruction word.
- `if_pc`  in  XLEN  address of the fetched instruction.
- `if_take`  in  1  fetch predicted this instruction as taken.
- `id_valid`  out  1  head entry valid.
- `id_ready`  in  1  decode consumes head (inverse of EX stall).
- `id_inst`  out  32  head instruction, or `NOP_INST` when `id_valid`=0.
- `id_pc`  out  XLEN  head PC+4, or 0 when `id_valid`=0.
- `id_take`  out  1  head prediction bit, or 0 when `id_valid`=0.
- `id_jump`  in  1  decode identifies head as an unconditional jump.
- `ex_flush`  in  1  EX branch resolved opposite to its prediction.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
Storage and pointers:
- Circular storage of {inst[31:0], pc_plus4[XLEN-1:0], take}.
- Write and read pointers are max(1,$clog2(DEPTH)) bits and wrap modulo DEPTH.

Handshakes:
- push = `if_valid` && `if_ready`.
- pop = `id_valid` && `id_ready`.
- `if_ready` = (`count` != DEPTH). It is registered-state only, with no combinational path from `id_ready`.
- `id_valid` = (`count` != 0).
- `id_*` are driven from the head entry, muxed to bubble values when empty.

Write data:
- Stored pc_plus4 = `if_pc` + 4, truncated to XLEN bits (wraps at 2^XLEN).

Per-edge priority, highest first:
1. `reset`: count=0, pointers=0, storage need not clear.
2. `ex_flush`: count=0, read pointer = write pointer. Incoming fetch is discarded even if `if_valid`; no push.
3. `id_jump` && pop: head consumed, all younger entries and the incoming fetch discarded; count=0, no push.
4. Normal: push and/or pop.
   - Both in the same cycle: count unchanged, both pointers advance.

Ignored inputs:
- `id_jump` with `id_ready`=0 is ignored; stall dominates and the head is held.
- `id_jump` with `id_valid`=0 is ignored.

Ordering:
- Strict FIFO; entries are never reordered or duplicated.
- A held head (`id_ready`=0) keeps `id_inst`/`id_pc`/`id_take` stable.

## Timing
Reset values:
- `id_valid`=0, `id_inst`=`NOP_INST`, `id_pc`=0, `id_take`=0, `count`=0.
- `if_ready`=1.

Latency:
- A fetch pushed at edge N into an empty queue is on `id_*` from edge N up to the next edge (one-cycle latency, same as the former register).
- No combinational `if_*` → `id_*` bypass.

Occupancy and flush:
- Full: `if_ready`=0 from the edge that fills the last entry. It returns to 1 the edge after the first pop.
- Full with a same-cycle pop: fetch still refused that cycle.
- `ex_flush`/`id_jump` take effect at the edge. The next cycle shows `id_valid`=0, bubble outputs and `if_ready`=1.
- `reset` asserted mid-operation clears immediately (asynchronously), independent of `clk`.
- `DEPTH`=1 degenerates to a single register with handshake. Throughput is then one instruction per two cycles when `if_ready` gating applies.

## Test plan
- Reset, then push `if_inst`=32'h00500093, `if_pc`=0x100, `if_take`=1 → next cycle `id_valid`=1, `id_inst`=32'h00500093, `id_pc`=0x104, `id_take`=1, `count`=1.
- DEPTH=2, `id_ready`=0, push 3 instructions at 0x0/0x4/0x8 → `count`=2, `if_ready`=0, third fetch not accepted. Then `id_ready`=1 → decode sees PCs 0x4, 0x8 in order; `count` returns to 0.
- Queue holding 2 entries, `ex_flush`=1 with `if_valid`=1 → next cycle `count`=0, `id_inst`=`NOP_INST`, `id_pc`=0; flushed-cycle fetch never appears.
- Head is jump, `id_jump`=1, `id_ready`=1, one younger entry plus incoming fetch → both discarded, `count`=0. Repeat with `id_ready`=0 → head held, `count` unchanged.
- Simultaneous push and pop at `count`=1 → `count` stays 1, head advances. `if_pc`=0xFFFF_FFFC → `id_pc`=0x0000_0000.
- Assert `reset` between clock edges with `count`=2 → outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/if_id_buffer.sv
// Fetch/decode boundary queue: DEPTH-entry in-order FIFO with valid/ready on both sides,
// carrying {inst, pc+4, predicted-taken}; EX flush and ID jump squash empty it to a bubble.
module if_id_buffer #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [31:0]                  if_inst,
    input  logic [XLEN-1:0]              if_pc,
    input  logic                         if_take,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [31:0]                  id_inst,
    output logic [XLEN-1:0]              id_pc,
    output logic                         id_take,
    input  logic                         id_jump,
    input  logic                         ex_flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]     r_inst [DEPTH];
    logic [XLEN-1:0] r_pc4  [DEPTH];
    logic            r_take [DEPTH];

    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_count;

    logic            w_valid;
    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_squash;
    logic [PW-1:0]   w_wr_next;
    logic [PW-1:0]   w_rd_next;

    // Both handshake flags depend only on registered occupancy, so if_ready has no path from id_ready.
    assign w_valid   = (r_count != '0);
    assign w_ready   = (r_count != FULL);
    assign w_push    = if_valid && w_ready;
    assign w_pop     = w_valid && id_ready;
    assign w_squash  = ex_flush || (id_jump && w_pop);
    assign w_wr_next = (r_wr == LAST) ? '0 : r_wr + PW'(1);
    assign w_rd_next = (r_rd == LAST) ? '0 : r_rd + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (w_squash) begin
            // Flush or taken jump: everything queued and the incoming fetch are dropped.
            r_rd    <= r_wr;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= w_wr_next;
            if (w_pop)  r_rd <= w_rd_next;
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_squash) begin
            r_inst[r_wr] <= if_inst;
            r_pc4[r_wr]  <= if_pc + XLEN'(4);
            r_take[r_wr] <= if_take;
        end
    end

    always_comb begin
        if_ready = w_ready;
        id_valid = w_valid;
        count    = r_count;
        id_inst  = NOP_INST;
        id_pc    = '0;
        id_take  = 1'b0;
        if (w_valid) begin
            id_inst = r_inst[r_rd];
            id_pc   = r_pc4[r_rd];
            id_take = r_take[r_rd];
        end
    end

endmodule
